// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the ram_arb shared-memory block.
//   - state_t     : sweep controller state (IDLE=0, CLEAR=1)
//   - idx_width() : width of a channel index, never less than 1 bit
//   - ch_lsb()    : LSB of channel k inside a packed per-channel bus
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int MAX_CH = 8;

  // A single channel still needs a 1-bit index so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Offset of channel k in a bus packed as NUM_CH slices of width w.
  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: request/grant/data bundle between the requesters and ram_arb.
//   req_i/we_i      per-channel request and write enable
//   addr_i/wdata_i  packed per-channel address and write data
//   gnt_o           one-hot grant (combinational)
//   rvalid_o        one-hot read-data-valid, one cycle after a read grant
//   rdata_o         shared read data
//   clear_i/busy_o  zero-fill sweep start pulse and sweep-running flag
// Modports: master (requester side), slave (ram_arb side).
interface ram_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 3
);
  logic [NUM_CH-1:0]            req_i;
  logic [NUM_CH-1:0]            we_i;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CH*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_CH-1:0]            gnt_o;
  logic [NUM_CH-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]        rdata_o;
  logic                         clear_i;
  logic                         busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, clear_i,
    input  gnt_o, rvalid_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, clear_i,
    output gnt_o, rvalid_o, rdata_o, busy_o
  );
endinterface

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with an internal last-grant pointer.
//   clk, rst  clock and synchronous active-high reset
//   req       per-channel request
//   en        arbitration enable (low forces no grant)
//   advance   load the pointer with the current winner
//   gnt       one-hot grant (combinational)
//   index     binary index of the granted channel
import ram_arb_pkg::*;

module rr_arb #(
  parameter int NUM_CH = 3,
  localparam int IDX_W = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  index
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;
  int               w_sum;

  // Scan from the channel after the last winner, wrapping once around.
  always_comb begin
    gnt     = '0;
    index   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_pos   = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      w_sum = int'(r_ptr) + off;
      if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
      w_pos = IDX_W'(w_sum);
      if (en && !w_found && req[w_pos]) begin
        w_found    = 1'b1;
        gnt[w_pos] = 1'b1;
        index      = w_pos;
      end
    end
  end

  // Reset value makes channel 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_W'(NUM_CH - 1);
    end else if (advance) begin
      r_ptr <= index;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// ram_arb: single-port RAM (2^ADDR_WIDTH x DATA_WIDTH) shared by NUM_CH
// requesters through a round-robin arbiter, with a zero-fill sweep.
//   clk, rst  clock and synchronous active-high reset
//   bus       ram_arb_if slave: requests, grants, read data, clear/busy
// The RAM array itself is never reset.
import ram_arb_pkg::*;

module ram_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 3
) (
  input  logic     clk,
  input  logic     rst,
  ram_arb_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [NUM_CH-1:0]       r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_ch_addr  [NUM_CH];
  logic [DATA_WIDTH-1:0]   w_ch_wdata [NUM_CH];
  logic [NUM_CH-1:0]       w_gnt;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_arb_en;
  logic                    w_any_gnt;
  logic                    w_sel_we;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;

  // Unpack the per-channel buses into arrays indexed by channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_addr[gi]  = bus.addr_i[ch_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
      assign w_ch_wdata[gi] = bus.wdata_i[ch_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
    end
  endgenerate

  assign w_arb_en  = (r_state == ST_IDLE);
  assign w_any_gnt = |w_gnt;
  assign w_sel_we  = bus.we_i[w_idx];

  rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_i),
    .en      (w_arb_en),
    .advance (w_any_gnt),
    .gnt     (w_gnt),
    .index   (w_idx)
  );

  // Single RAM port: the sweep owns it in CLEAR, the winner owns it in IDLE.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_ch_addr[w_idx];
    w_mem_wdata = w_ch_wdata[w_idx];
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = '0;
    end else begin
      w_mem_we = w_any_gnt && w_sel_we;
    end
  end

  // Writes are suppressed during reset so an aborted sweep stops exactly
  // at the last address written before rst.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_state == ST_IDLE) begin
        if (w_any_gnt && !w_sel_we) begin
          r_rvalid <= w_gnt;
          r_rdata  <= r_mem[w_mem_addr];
        end
        // A grant in the clear_i cycle has already been serviced above.
        if (bus.clear_i) begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign bus.busy_o   = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed scenarios plus randomized traffic for ram_arb
// (NUM_CH=3, DATA_WIDTH=8, ADDR_WIDTH=4), checked every cycle against a
// behavioural model of the memory, arbitration order and sweep.
module tb_ram_arb;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NC    = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();

  ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_init   = 1'b0;
  bit              m_busy   = 1'b0;
  int              m_cnt    = 0;
  int              m_last   = NC - 1;
  logic [DW-1:0]   m_mem   [DEPTH];
  bit              m_known [DEPTH];
  logic [NC-1:0]   m_rvalid = '0;
  logic [DW-1:0]   m_rdata  = '0;
  bit              m_rdata_known = 1'b1;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  // Winner is the first requester after the last winner, cyclically.
  function automatic logic [NC-1:0] model_gnt();
    logic [NC-1:0] r;
    int c;
    r = bus.req_i;
    if (m_busy) return '0;
    for (int off = 1; off <= NC; off++) begin
      c = (m_last + off) % NC;
      if (r[c[1:0]]) return NC'(1 << c);
    end
    return '0;
  endfunction

  always @(negedge clk) begin
    logic [NC-1:0] eg;
    logic [NC-1:0] wev;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int g;
    eg = model_gnt();
    if (m_init) begin
      cmp("gnt_o", 32'(bus.gnt_o), 32'(eg));
      cmp("busy_o", 32'(bus.busy_o), 32'(m_busy));
      cmp("rvalid_o", 32'(bus.rvalid_o), 32'(m_rvalid));
      if (m_rdata_known) cmp("rdata_o", 32'(bus.rdata_o), 32'(m_rdata));
    end
    if (rst) begin
      m_init = 1'b1; m_busy = 1'b0; m_cnt = 0; m_last = NC - 1;
      m_rvalid = '0; m_rdata = '0; m_rdata_known = 1'b1;
    end else if (m_init) begin
      m_rvalid = '0;
      if (m_busy) begin
        m_mem[4'(m_cnt)] = '0;
        m_known[4'(m_cnt)] = 1'b1;
        if (m_cnt == DEPTH - 1) m_busy = 1'b0;
        m_cnt++;
      end else begin
        if (eg != 0) begin
          g = 0;
          for (int k = 0; k < NC; k++) if (((eg >> k) & 3'b001) != 0) g = k;
          m_last = g;
          a   = AW'(bus.addr_i >> (g * AW));
          d   = DW'(bus.wdata_i >> (g * DW));
          wev = bus.we_i;
          if (((wev >> g) & 3'b001) != 0) begin
            m_mem[a] = d;
            m_known[a] = 1'b1;
          end else begin
            m_rvalid = eg;
            m_rdata = m_mem[a];
            m_rdata_known = m_known[a];
          end
        end
        if (bus.clear_i) begin
          m_busy = 1'b1;
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs only change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.clear_i = 1'b0;
  endtask

  task automatic set_ch(input int k, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_i = bus.req_i | NC'(1 << k);
    if (we) bus.we_i = bus.we_i | NC'(1 << k);
    else    bus.we_i = bus.we_i & ~NC'(1 << k);
    bus.addr_i  = (bus.addr_i & ~((NC*AW)'(4'hF) << (k*AW))) | ((NC*AW)'(a) << (k*AW));
    bus.wdata_i = (bus.wdata_i & ~((NC*DW)'(8'hFF) << (k*DW))) | ((NC*DW)'(d) << (k*DW));
  endtask

  task automatic rd_check(input int k, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    idle_in();
    set_ch(k, 1'b0, a, '0);
    step();
    idle_in();
    @(negedge clk);
    cmp(name, 32'(bus.rdata_o), 32'(exp));
    step();
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int a = 0; a < DEPTH; a++) begin
      idle_in();
      set_ch(0, 1'b1, AW'(a), v);
      step();
    end
    idle_in();
  endtask

  // Counts busy cycles from the current cycle on; re-pulses clear_i once
  // after busy cycle `repulse` when repulse > 0.
  task automatic count_busy(output int n, input int repulse);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
      n++;
      cmp("sweep_gnt", 32'(bus.gnt_o), 32'd0);
      step();
      bus.clear_i = (repulse > 0 && n == repulse);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  logic [NC-1:0] rr_exp [6];
  int n;

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    idle_in();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    cmp("reset_busy", 32'(bus.busy_o), 32'd0);
    cmp("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
    cmp("reset_rdata", 32'(bus.rdata_o), 32'd0);
    step();
    rst = 1'b0;

    // ch1 writes A5 @3, then ch2 reads it back
    set_ch(1, 1'b1, 4'd3, 8'hA5);
    @(negedge clk); cmp("s1_gnt_wr", 32'(bus.gnt_o), 32'b010);
    step(); idle_in();
    set_ch(2, 1'b0, 4'd3, '0);
    @(negedge clk); cmp("s1_gnt_rd", 32'(bus.gnt_o), 32'b100);
    step(); idle_in();
    @(negedge clk);
    cmp("s1_rvalid", 32'(bus.rvalid_o), 32'b100);
    cmp("s1_rdata", 32'(bus.rdata_o), 32'hA5);
    step();

    // three channels reading continuously
    for (int i = 0; i < 6; i++) begin
      idle_in();
      for (int k = 0; k < NC; k++) set_ch(k, 1'b0, AW'($urandom_range(0, 15)), '0);
      @(negedge clk);
      cmp("rr_gnt", 32'(bus.gnt_o), 32'(rr_exp[i]));
      step();
    end
    idle_in();
    step();

    // fill with 0x11, sweep while ch0 keeps requesting
    fill(8'h11);
    set_ch(0, 1'b0, 4'd5, '0);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    count_busy(n, 0);
    cmp("sweep_len", 32'(n), 32'd16);
    cmp("gnt_at_busy_fall", 32'(bus.gnt_o), 32'b001);
    step();
    for (int a = 0; a < DEPTH; a++) rd_check(0, AW'(a), 8'h00, "cleared_rd");

    // clear_i re-pulsed mid-sweep does not restart it
    fill(8'h11);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    count_busy(n, 5);
    cmp("sweep_len_repulse", 32'(n), 32'd16);
    idle_in();
    step();

    // reset aborts a sweep after 8 addresses
    fill(8'h11);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp("abort_busy", 32'(bus.busy_o), 32'd0);
    cmp("abort_rvalid", 32'(bus.rvalid_o), 32'd0);
    step();
    for (int a = 0; a < DEPTH; a++)
      rd_check(1, AW'(a), (a < 8) ? 8'h00 : 8'h11, "abort_rd");

    // clear_i together with a ch2 write to addr 15
    idle_in();
    set_ch(2, 1'b1, 4'd15, 8'h3C);
    bus.clear_i = 1'b1;
    @(negedge clk); cmp("clr_wr_gnt", 32'(bus.gnt_o), 32'b100);
    step();
    idle_in();
    count_busy(n, 0);
    cmp("clr_wr_len", 32'(n), 32'd16);
    step();
    rd_check(0, 4'd15, 8'h00, "clr_wr_rd15");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.req_i   = NC'($urandom);
      bus.we_i    = NC'($urandom);
      bus.addr_i  = (NC*AW)'($urandom);
      bus.wdata_i = (NC*DW)'($urandom);
      bus.clear_i = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_in();
    rst = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Parametrised shared-memory block: one synchronous single-port RAM of 2^ADDR_WIDTH words × DATA_WIDTH bits, shared by NUM_CH requesters through a round-robin arbiter. Includes a hardware clear sweep that zero-fills the whole array.
- Sits between the chip8 core's clients (CPU fetch/execute, display refresh, UART loader) and on-chip block RAM.
- Replaces the single-client, fixed-width RAM hookup used so far.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 12, address width; depth = 2^ADDR_WIDTH
- NUM_CH, 3, number of requester channels (1..8)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_i  in  NUM_CH  per-channel request, held until granted
- we_i  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
- addr_i  in  NUM_CH*ADDR_WIDTH  packed addresses; channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata_i  in  NUM_CH*DATA_WIDTH  packed write data; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- gnt_o  out  NUM_CH  one-hot grant, combinational, same cycle as the accepted request
- rvalid_o  out  NUM_CH  one-hot read-data-valid, one cycle after a read grant
- rdata_o  out  DATA_WIDTH  shared read data, qualified by rvalid_o
- clear_i  in  1  single-cycle pulse; starts the zero-fill sweep
- busy_o  out  1  high while the sweep is running

## Operation
- States: IDLE, CLEAR.
- IDLE:
  - Each cycle, grant at most one channel with req_i=1.
  - Search order starts at ptr+1 mod NUM_CH and wraps.
  - The granted channel's transaction executes on the RAM in that cycle.
  - After any grant, ptr = granted index. With no grant, ptr holds.
- Write grant: mem[addr] <= wdata at the clock edge. No rvalid is generated.
- Read grant: rdata_o = mem[addr] and rvalid_o[k]=1 on the following cycle.
- Requester protocol:
  - Deassert req_i, or present a new request, in the cycle after the grant.
  - A request held into the next cycle counts as a new transaction.
- clear_i in IDLE:
  - Move to CLEAR and set cnt = 0.
  - A request granted in that same cycle still completes.
  - The sweep starts on the next cycle.
- CLEAR:
  - Each cycle write 0 to mem[cnt], then cnt++.
  - gnt_o = 0 for all channels.
  - When cnt = 2^ADDR_WIDTH−1 is written, return to IDLE.
  - Duration is exactly 2^ADDR_WIDTH cycles.
- clear_i during CLEAR is ignored; the sweep is not restarted.
- rst:
  - Sets state=IDLE, ptr=NUM_CH−1 (so channel 0 wins first), cnt=0, rvalid_o=0, rdata_o=0, busy_o=0.
  - Memory contents are not reset.
  - rst in the middle of a sweep aborts it and leaves the array partially cleared.
- NUM_CH=1: the arbiter degenerates to gnt_o = req_i & ~busy_o.

## Timing
- Grant latency: 0 cycles (combinational from req_i, ptr, state).
- Read latency: 1 cycle from the grant edge to rvalid_o/rdata_o.
- rdata_o holds its last value when rvalid_o=0.
- Write followed by a read of the same address in the next cycle, any channel: returns the new data (no bypass needed).
- busy_o:
  - Rises the cycle after clear_i.
  - Stays high for 2^ADDR_WIDTH cycles.
  - First grant is possible in the cycle busy_o falls.
- Arbiter fairness: a continuously requesting channel is granted within NUM_CH cycles while in IDLE.

## Structure
- Shared package:
  - Packed-bus slice helper localparams for channel k offsets.
  - State encoding: IDLE=0, CLEAR=1.
- Sub-module rr_arb:
  - Parameter NUM_CH.
  - Inputs req, en, advance. Outputs one-hot gnt, index.
  - Holds ptr internally and resets synchronously.
- Storage: inferred single-port block RAM inside ram_arb.
  - Registered read, no reset on the array.
  - Write port muxed between the granted channel and the sweep counter.

## Test plan
- Config for all scenarios: NUM_CH=3, DATA_WIDTH=8, ADDR_WIDTH=4.
- Reset, then ch1 writes 0xA5 to addr 3; next cycle ch2 reads addr 3:
  - gnt_o=010, then 100.
  - rvalid_o=100 with rdata_o=0xA5 one cycle later.
- All three channels hold read requests for 6 cycles:
  - Grants follow 001,010,100,001,010,100.
  - rvalid_o trails each grant by one cycle.
- Write 0x11 to all 16 addresses, pulse clear_i, with ch0 requesting throughout:
  - busy_o high for exactly 16 cycles, gnt_o=000 throughout.
  - Subsequent reads of addrs 0..15 all return 0x00.
- clear_i pulsed again at cycle 5 of an active sweep:
  - busy_o still falls after 16 cycles total; there is no restart.
- rst asserted at cycle 8 of a sweep over an array filled with 0x11:
  - busy_o=0 and rvalid_o=0 on the next cycle.
  - addrs 0..7 read 0x00 and addrs 8..15 read 0x11.
- clear_i asserted in the same cycle ch2 writes 0x3C to addr 15:
  - The write completes and the sweep starts next cycle.
  - addr 15 finally reads 0x00.
